// File: rtl/instr_cycle_ctrl.sv
// instr_cycle_ctrl
//   Multi-cycle control FSM for a simple fetch/decode/execute datapath.
//   It sequences the fetch unit (write_ir, write_pc, pc_s) and drives the ALU,
//   data-memory and register-file strobes according to the instruction class.
//   It also counts retired instructions.
//   All strobes are registered Moore outputs. They change only on posedge clk,
//   so they are stable before the fetch unit captures on negedge.
//   Optional single-step debug mode: define CTRL_SINGLE_STEP_EN to add the
//   step / step_mode inputs. Without it, HALT is reached only through the halt
//   instruction.

module instr_cycle_ctrl #(
    parameter int unsigned MEM_WAIT = 1,   // extra MEM cycles for data-memory latency (0..15)
    parameter int unsigned CNT_W    = 32   // retired-instruction counter width
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      ir,
    input  logic             cond_ok,
`ifdef CTRL_SINGLE_STEP_EN
    input  logic             step,
    input  logic             step_mode,
`endif
    output logic             write_ir,
    output logic             write_pc,
    output logic [1:0]       pc_s,
    output logic             alu_en,
    output logic             mem_rd,
    output logic             mem_wr,
    output logic             write_reg,
    output logic             wb_sel_mem,
    output logic             instr_done,
    output logic [CNT_W-1:0] retired,
    output logic [2:0]       state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_e;

    typedef enum logic [1:0] {
        CLS_DP  = 2'b00,   // data processing
        CLS_LS  = 2'b01,   // load / store
        CLS_BR  = 2'b10,   // branch (optionally with link)
        CLS_JMP = 2'b11    // register jump
    } cls_e;

    localparam logic [3:0]  WAIT_LAST = 4'(MEM_WAIT);
    localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

    // Sequencing state
    state_e           state_q, state_d;
    cls_e             cls_q, cls_d;
    logic             load_q, load_d;
    logic             link_q, link_d;
    logic             skip_q, skip_d;
    logic             hard_q, hard_d;      // HALT entered through the halt instruction
    logic [3:0]       wait_q, wait_d;
    logic [CNT_W-1:0] retired_q, retired_d;

    // Registered strobes
    logic             write_ir_q, write_ir_d;
    logic             write_pc_q, write_pc_d;
    logic [1:0]       pc_s_q, pc_s_d;
    logic             alu_en_q, alu_en_d;
    logic             mem_rd_q, mem_rd_d;
    logic             mem_wr_q, mem_wr_d;
    logic             write_reg_q, write_reg_d;
    logic             wb_sel_mem_q, wb_sel_mem_d;
    logic             instr_done_q, instr_done_d;

    // Where the FSM goes whenever it would normally enter FETCH, and whether
    // a soft (single-step) HALT may be left this cycle.
    state_e           fetch_tgt;
    logic             step_go;

`ifdef CTRL_SINGLE_STEP_EN
    logic             step_q, step_d;
    logic             step_prev_q, step_prev_d;

    // Register step and keep its previous value for rising-edge detection
    always_comb begin
        step_d      = step;
        step_prev_d = step_q;
        fetch_tgt   = step_mode ? S_HALT : S_FETCH;
        step_go     = ~step_mode | (step_q & ~step_prev_q);
    end

    // Step synchroniser / edge-detect flops
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step_q      <= 1'b0;
            step_prev_q <= 1'b0;
        end else begin
            step_q      <= step_d;
            step_prev_q <= step_prev_d;
        end
    end
`else
    // Without single-step support, FETCH is always entered directly
    always_comb begin
        fetch_tgt = S_FETCH;
        step_go   = 1'b0;
    end
`endif

    // Next-state and per-instruction context
    always_comb begin
        // NOTE: every signal written here gets a default first, so no latch is inferred.
        state_d = state_q;
        cls_d   = cls_q;
        load_d  = load_q;
        link_d  = link_q;
        skip_d  = skip_q;
        hard_d  = hard_q;
        wait_d  = wait_q;

        case (state_q)
            S_IDLE: state_d = fetch_tgt;

            S_FETCH: begin
                skip_d  = ~cond_ok;
                state_d = S_DECODE;
            end

            S_DECODE: begin
                if (skip_q) begin
                    state_d = fetch_tgt;
                end else if (ir == HALT_WORD) begin
                    hard_d  = 1'b1;
                    state_d = S_HALT;
                end else begin
                    cls_d   = cls_e'(ir[27:26]);
                    load_d  = ir[20];
                    link_d  = ir[24];
                    state_d = S_EXEC;
                end
            end

            S_EXEC: begin
                case (cls_q)
                    CLS_DP: state_d = S_WB;
                    CLS_LS: begin
                        wait_d  = 4'd0;
                        state_d = S_MEM;
                    end
                    CLS_BR:  state_d = link_q ? S_WB : fetch_tgt;
                    default: state_d = fetch_tgt;
                endcase
            end

            S_MEM: begin
                if (wait_q == WAIT_LAST) begin
                    state_d = load_q ? S_WB : fetch_tgt;
                end else begin
                    wait_d = wait_q + 4'd1;
                end
            end

            S_WB: state_d = fetch_tgt;

            S_HALT: begin
                if (!hard_q && step_go) begin
                    state_d = S_FETCH;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // Moore strobes, decoded from the state being entered
    always_comb begin
        write_ir_d   = 1'b0;
        write_pc_d   = 1'b0;
        pc_s_d       = 2'b00;
        alu_en_d     = 1'b0;
        mem_rd_d     = 1'b0;
        mem_wr_d     = 1'b0;
        write_reg_d  = 1'b0;
        wb_sel_mem_d = 1'b0;
        instr_done_d = 1'b0;

        case (state_d)
            S_FETCH: begin
                write_ir_d = 1'b1;
                write_pc_d = 1'b1;
            end

            S_DECODE: instr_done_d = skip_d;   // annulled instructions still retire

            S_EXEC: begin
                alu_en_d = 1'b1;
                if (cls_d == CLS_BR) begin
                    write_pc_d   = 1'b1;
                    pc_s_d       = 2'b01;
                    instr_done_d = ~link_d;
                end else if (cls_d == CLS_JMP) begin
                    write_pc_d   = 1'b1;
                    pc_s_d       = 2'b10;
                    instr_done_d = 1'b1;
                end
            end

            S_MEM: begin
                mem_rd_d     = load_d;
                mem_wr_d     = ~load_d;
                instr_done_d = ~load_d && (wait_d == WAIT_LAST);
            end

            S_WB: begin
                write_reg_d  = 1'b1;
                wb_sel_mem_d = (cls_d == CLS_LS) && load_d;
                instr_done_d = 1'b1;
            end

            S_HALT: instr_done_d = hard_d & ~hard_q;   // halt instruction retires once

            default: ;
        endcase

        retired_d = retired_q + CNT_W'(instr_done_q);
    end

    // All state and output registers; reset clears them immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cls_q        <= CLS_DP;
            load_q       <= 1'b0;
            link_q       <= 1'b0;
            skip_q       <= 1'b0;
            hard_q       <= 1'b0;
            wait_q       <= 4'd0;
            retired_q    <= '0;
            write_ir_q   <= 1'b0;
            write_pc_q   <= 1'b0;
            pc_s_q       <= 2'b00;
            alu_en_q     <= 1'b0;
            mem_rd_q     <= 1'b0;
            mem_wr_q     <= 1'b0;
            write_reg_q  <= 1'b0;
            wb_sel_mem_q <= 1'b0;
            instr_done_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments, so every flop samples pre-edge values.
            state_q      <= state_d;
            cls_q        <= cls_d;
            load_q       <= load_d;
            link_q       <= link_d;
            skip_q       <= skip_d;
            hard_q       <= hard_d;
            wait_q       <= wait_d;
            retired_q    <= retired_d;
            write_ir_q   <= write_ir_d;
            write_pc_q   <= write_pc_d;
            pc_s_q       <= pc_s_d;
            alu_en_q     <= alu_en_d;
            mem_rd_q     <= mem_rd_d;
            mem_wr_q     <= mem_wr_d;
            write_reg_q  <= write_reg_d;
            wb_sel_mem_q <= wb_sel_mem_d;
            instr_done_q <= instr_done_d;
        end
    end

    assign write_ir   = write_ir_q;
    assign write_pc   = write_pc_q;
    assign pc_s       = pc_s_q;
    assign alu_en     = alu_en_q;
    assign mem_rd     = mem_rd_q;
    assign mem_wr     = mem_wr_q;
    assign write_reg  = write_reg_q;
    assign wb_sel_mem = wb_sel_mem_q;
    assign instr_done = instr_done_q;
    assign retired    = retired_q;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_instr_cycle_ctrl.sv
// Testbench for instr_cycle_ctrl (default build).
// The reference model expands each instruction into its expected per-cycle
// strobe table, using the instruction-class rules. The bench drives one
// instruction at a time and checks every cycle against that table.
// It also tracks the expected retired count.

module tb_instr_cycle_ctrl;

    localparam int MW = 1;
    localparam int CW = 4;

    localparam logic [31:0] DP_WORD   = 32'hE080_1002;   // [27:26]=00
    localparam logic [31:0] LD_WORD   = 32'hE590_0000;   // [27:26]=01, [20]=1
    localparam logic [31:0] BR_WORD   = 32'hEA00_0010;   // [27:26]=10, [24]=0
    localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

    typedef struct packed {
        logic [2:0] st;
        logic       wir;
        logic       wpc;
        logic [1:0] pcs;
        logic       alu;
        logic       rd;
        logic       wr;
        logic       wreg;
        logic       wbs;
        logic       done;
    } vec_t;

    logic          clk;
    logic          rst;
    logic [31:0]   ir;
    logic          cond_ok;
    logic          write_ir;
    logic          write_pc;
    logic [1:0]    pc_s;
    logic          alu_en;
    logic          mem_rd;
    logic          mem_wr;
    logic          write_reg;
    logic          wb_sel_mem;
    logic          instr_done;
    logic [CW-1:0] retired;
    logic [2:0]    state_dbg;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   exp_ret  = 0;
    vec_t exp_q[$];

    instr_cycle_ctrl #(.MEM_WAIT(MW), .CNT_W(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .ir         (ir),
        .cond_ok    (cond_ok),
        .write_ir   (write_ir),
        .write_pc   (write_pc),
        .pc_s       (pc_s),
        .alu_en     (alu_en),
        .mem_rd     (mem_rd),
        .mem_wr     (mem_wr),
        .write_reg  (write_reg),
        .wb_sel_mem (wb_sel_mem),
        .instr_done (instr_done),
        .retired    (retired),
        .state_dbg  (state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] dut_vec();
        vec_t v;
        v = {state_dbg, write_ir, write_pc, pc_s, alu_en, mem_rd, mem_wr,
             write_reg, wb_sel_mem, instr_done};
        return {18'd0, v};
    endfunction

    function automatic logic [31:0] ret_val();
        return {{(32-CW){1'b0}}, retired};
    endfunction

    function automatic void push(input int st, input bit wir, input bit wpc, input int pcs,
                                 input bit alu, input bit rd, input bit wr, input bit wreg,
                                 input bit wbs, input bit done);
        vec_t v;
        v.st   = 3'(st);
        v.wir  = wir;
        v.wpc  = wpc;
        v.pcs  = 2'(pcs);
        v.alu  = alu;
        v.rd   = rd;
        v.wr   = wr;
        v.wreg = wreg;
        v.wbs  = wbs;
        v.done = done;
        exp_q.push_back(v);
    endfunction

    // Drive one instruction and append its expected per-cycle strobe table.
    // State numbers: IDLE=0 FETCH=1 DECODE=2 EXEC=3 MEM=4 WB=5 HALT=6
    task automatic gen(input logic [31:0] w, input bit ok, input int halt_cycles);
        ir      = w;
        cond_ok = ok;
        push(1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        if (!ok) begin
            push(2, 0, 0, 0, 0, 0, 0, 0, 0, 1);
            return;
        end
        push(2, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        if (w == HALT_WORD) begin
            push(6, 0, 0, 0, 0, 0, 0, 0, 0, 1);
            for (int i = 1; i < halt_cycles; i++) push(6, 0, 0, 0, 0, 0, 0, 0, 0, 0);
            return;
        end
        case (w[27:26])
            2'b00: begin
                push(3, 0, 0, 0, 1, 0, 0, 0, 0, 0);
                push(5, 0, 0, 0, 0, 0, 0, 1, 0, 1);
            end
            2'b01: begin
                push(3, 0, 0, 0, 1, 0, 0, 0, 0, 0);
                for (int i = 0; i <= MW; i++)
                    push(4, 0, 0, 0, 0, w[20], !w[20], 0, 0, !w[20] && (i == MW));
                if (w[20]) push(5, 0, 0, 0, 0, 0, 0, 1, 1, 1);
            end
            2'b10: begin
                push(3, 0, 1, 1, 1, 0, 0, 0, 0, !w[24]);
                if (w[24]) push(5, 0, 0, 0, 0, 0, 0, 1, 0, 1);
            end
            default: push(3, 0, 1, 2, 1, 0, 0, 0, 0, 1);
        endcase
    endtask

    // Compare process: one expected vector per cycle, sampled on negedge
    task automatic drain(input int n_max, output int rd_cycles);
        vec_t e;
        rd_cycles = 0;
        for (int i = 0; i < n_max && exp_q.size() > 0; i++) begin
            e = exp_q.pop_front();
            @(posedge clk);
            @(negedge clk);
            check("cycle_outputs", dut_vec(), {18'd0, e});
            check("retired", ret_val(), 32'(exp_ret));
            if (mem_rd) rd_cycles++;
            if (e.done) exp_ret = (exp_ret + 1) % (1 << CW);
        end
    endtask

    // Asynchronous reset mid-cycle, then release on a negedge (FSM sits in IDLE)
    task automatic do_reset();
        #2 rst = 1'b1;
        #1;
        check("reset_outputs", dut_vec(), 32'd0);
        check("reset_retired", ret_val(), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        exp_ret = 0;
        #1;
        check("idle_outputs", dut_vec(), 32'd0);
    endtask

    initial begin
        int          rd;
        logic [31:0] w;
        bit          ok;

        rst     = 1'b0;
        ir      = DP_WORD;
        cond_ok = 1'b1;
        do_reset();

        // Data-processing: FETCH, DECODE, EXEC, WB
        gen(DP_WORD, 1'b1, 0);
        check("dp_len", 32'(exp_q.size()), 32'd4);
        drain(100, rd);

        // Load: mem_rd for MEM_WAIT+1 cycles, then WB from memory
        gen(LD_WORD, 1'b1, 0);
        check("ld_len", 32'(exp_q.size()), 32'd6);
        drain(1, rd);
        check("retired_after_dp", ret_val(), 32'd1);
        drain(100, rd);
        check("ld_rd_cycles", 32'(rd), 32'd2);

        // Branch without link
        gen(BR_WORD, 1'b1, 0);
        check("br_len", 32'(exp_q.size()), 32'd3);
        drain(100, rd);

        // Annulled instruction
        gen(DP_WORD, 1'b0, 0);
        check("annul_len", 32'(exp_q.size()), 32'd2);
        drain(100, rd);

        // Halt instruction held for 20 cycles
        gen(HALT_WORD, 1'b1, 20);
        check("halt_len", 32'(exp_q.size()), 32'd22);
        drain(100, rd);
        check("halt_retired", ret_val(), 32'd5);

        // Reset out of HALT, then reset again in the middle of a load's MEM phase
        do_reset();
        gen(LD_WORD, 1'b1, 0);
        drain(4, rd);
        check("mid_mem_rd", 32'(mem_rd), 32'd1);
        do_reset();
        gen(LD_WORD, 1'b1, 0);
        drain(100, rd);
        check("ld_after_reset_rd_cycles", 32'(rd), 32'd2);

        // Randomised instruction stream
        for (int n = 0; n < 250; n++) begin
            w = $urandom;
            w[27:26] = 2'($urandom_range(0, 3));
            if (w == HALT_WORD) w[0] = 1'b0;
            ok = ($urandom_range(0, 4) != 0);
            gen(w, ok, 0);
            drain(100, rd);
        end

        // Counter wrap: 16 retirements bring a 4-bit count back to 0
        do_reset();
        for (int n = 0; n <= 16; n++) begin
            gen(DP_WORD, 1'b1, 0);
            drain(1, rd);
            if (n == 15) check("wrap_pre", ret_val(), 32'd15);
            if (n == 16) check("wrap_zero", ret_val(), 32'd0);
            drain(100, rd);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
